mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
Memory-access stage of the 16-bit pipelined MIPS. It consumes the execute stage's ALU result and B operand and drives loads/stores to data memory over a req/ack handshake. It stalls upstream stages while an access is outstanding and presents registered writeback data to the register file.

Parameters:
DATA_W, 16, datapath and memory word width
REG_ADDR_W, 3, destination register index width
TIMEOUT_CYCLES, 64, max wait for i_Mem_Ack (used only with MEM_TIMEOUT_EN)

Ports:
i_Clk  in  1  clock, rising edge
i_Reset  in  1  synchronous, active-high reset
i_Valid  in  1  execute-stage instruction valid this cycle
i_ALU_Result  in  DATA_W  address for mem ops; result for ALU ops
i_B  in  DATA_W  store data
i_Write_Reg  in  REG_ADDR_W  destination register
i_Sig_MemRead  in  1  load
i_Sig_MemWrite  in  1  store
i_Sig_RegWrite  in  1  instruction writes the register file
i_Sig_MemtoReg  in  1  writeback selects memory data over ALU result
o_Stall  out  1  upstream must hold its current instruction
o_Mem_Req  out  1  memory request, held until ack
o_Mem_We  out  1  1=write, 0=read; valid with o_Mem_Req
o_Mem_Addr  out  DATA_W  access address
o_Mem_Wdata  out  DATA_W  store data
i_Mem_Ack  in  1  memory completes the access this cycle
i_Mem_Rdata  in  DATA_W  read data, valid with i_Mem_Ack on a read
o_WB_Valid  out  1  one-cycle pulse per retired instruction
o_WB_RegWrite  out  1  register-file write enable
o_WB_Reg  out  REG_ADDR_W  register-file write address
o_WB_Data  out  DATA_W  register-file write data

Behaviour:
- One clock, i_Clk. Reset is synchronous and active-high on i_Reset.
- All outputs are registered. o_Stall is decoded directly from state.
- Reset values: state IDLE; all outputs 0.
- FSM states: IDLE and ACCESS.
- IDLE, i_Valid=0: o_WB_Valid=0 on the next edge.
- IDLE, i_Valid=1, no mem op:
  - Next edge: o_WB_Valid=1, o_WB_Data=i_ALU_Result, o_WB_Reg=i_Write_Reg, o_WB_RegWrite=i_Sig_RegWrite.
  - Latency 1; no stall.
- IDLE, i_Valid=1, MemRead or MemWrite:
  - Latch address, wdata, reg, RegWrite, MemtoReg.
  - Next edge: o_Mem_Req=1, o_Mem_We=i_Sig_MemWrite, state=ACCESS, o_WB_Valid=0.
  - If both MemRead and MemWrite are set, the access is a write.
- ACCESS:
  - o_Stall=1. o_Mem_Req/We/Addr/Wdata stay constant.
  - i_Valid and all datapath inputs are ignored.
- ACCESS with i_Mem_Ack=1, next edge:
  - o_Mem_Req=0, state=IDLE, o_WB_Valid=1.
  - o_WB_Data = i_Mem_Rdata if read and MemtoReg, else the latched address.
  - Stores retire with o_WB_RegWrite=0.
- Minimum memory-op latency: accept edge → req edge → ack cycle → WB edge, i.e. 2 cycles after accept for zero-wait memory.
- Upstream contract: the instruction presented while o_Stall=1 is held and accepted in the first IDLE cycle. No instruction is lost or duplicated.
- i_Mem_Ack when o_Mem_Req=0 is ignored.
- o_WB_RegWrite is forced to 0 whenever o_WB_Reg=0 (register $0 is read-only).
- o_WB_Valid is a single-cycle pulse. It is 0 in every cycle without a retire.
- Reset mid-access: the request is dropped on the same edge (o_Mem_Req=0), state returns to IDLE, and no writeback occurs. A late ack after reset is ignored.

Optional Feature:
Macro MEM_TIMEOUT_EN.
- With it:
  - A counter runs in ACCESS and clears on entering ACCESS.
  - If TIMEOUT_CYCLES cycles elapse without ack: drop o_Mem_Req, return to IDLE, retire with o_WB_Valid=1, o_WB_RegWrite=0, o_WB_Data=0.
  - Add output o_Mem_Error (1 bit), pulsed with that o_WB_Valid. It resets to 0.
  - If ack and timeout occur in the same cycle, ack wins.
- Without it: no counter and no o_Mem_Error port. The stage waits for ack indefinitely.

Test Plan:
- ALU op: i_Valid=1, ALU_Result=0x1234, Write_Reg=3, RegWrite=1 → next cycle WB_Valid=1, WB_Data=0x1234, WB_Reg=3, WB_RegWrite=1; o_Stall never asserted.
- Load, zero wait: MemRead, MemtoReg, addr 0x0040, reg 5; ack in the first req cycle with Rdata=0xBEEF → Mem_Req high 1 cycle, Mem_We=0, WB_Data=0xBEEF, WB_Reg=5 one edge after ack.
- Store, 3-cycle wait: MemWrite, addr 0x0010, B=0xA5A5; ack on the 3rd req cycle → Addr/Wdata stable for all 3 cycles, Stall=1 for 3 cycles, WB_Valid pulse with WB_RegWrite=0; the held next ALU op retires on the following cycle.
- Reg $0 / spurious ack: ALU op to reg 0 → WB_RegWrite=0; ack asserted in IDLE → no req and no WB effect.
- Reset mid-access: load outstanding 2 cycles, pulse i_Reset → next cycle all outputs 0, state IDLE; an ack arriving afterwards produces no WB_Valid.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4: load with ack never asserted → after 4 ACCESS cycles Mem_Req=0, WB_Valid=1, WB_Data=0, o_Mem_Error=1 for one cycle.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access stage of the 16-bit pipelined MIPS: data-memory req/ack and writeback.
// Optional MEM_TIMEOUT_EN adds an ack timeout and the o_Mem_Error output.
module mem_access_stage #(
   parameter int DATA_W     = 16,
   parameter int REG_ADDR_W = 3
`ifdef MEM_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 64
`endif
) (
   input  logic                  i_Clk,
   input  logic                  i_Reset,
   input  logic                  i_Valid,
   input  logic [DATA_W-1:0]     i_ALU_Result,
   input  logic [DATA_W-1:0]     i_B,
   input  logic [REG_ADDR_W-1:0] i_Write_Reg,
   input  logic                  i_Sig_MemRead,
   input  logic                  i_Sig_MemWrite,
   input  logic                  i_Sig_RegWrite,
   input  logic                  i_Sig_MemtoReg,
   output logic                  o_Stall,
   output logic                  o_Mem_Req,
   output logic                  o_Mem_We,
   output logic [DATA_W-1:0]     o_Mem_Addr,
   output logic [DATA_W-1:0]     o_Mem_Wdata,
   input  logic                  i_Mem_Ack,
   input  logic [DATA_W-1:0]     i_Mem_Rdata,
`ifdef MEM_TIMEOUT_EN
   output logic                  o_Mem_Error,
`endif
   output logic                  o_WB_Valid,
   output logic                  o_WB_RegWrite,
   output logic [REG_ADDR_W-1:0] o_WB_Reg,
   output logic [DATA_W-1:0]     o_WB_Data
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t                state_q, state_d;
   logic                  req_q, req_d;
   logic                  we_q, we_d;
   logic [DATA_W-1:0]     addr_q, addr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic [REG_ADDR_W-1:0] lreg_q, lreg_d;
   logic                  lrw_q, lrw_d;
   logic                  m2r_q, m2r_d;
   logic                  wbv_q, wbv_d;
   logic                  wbrw_q, wbrw_d;
   logic [REG_ADDR_W-1:0] wbreg_q, wbreg_d;
   logic [DATA_W-1:0]     wbdata_q, wbdata_d;
`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  err_q, err_d;
   logic                  tmo;
   assign tmo = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      lreg_d   = lreg_q;
      lrw_d    = lrw_q;
      m2r_d    = m2r_q;
      wbv_d    = 1'b0;
      wbrw_d   = wbrw_q;
      wbreg_d  = wbreg_q;
      wbdata_d = wbdata_q;
`ifdef MEM_TIMEOUT_EN
      cnt_d    = cnt_q;
      err_d    = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (i_Valid) begin
               if (i_Sig_MemRead || i_Sig_MemWrite) begin
                  state_d = ACCESS;
                  req_d   = 1'b1;
                  we_d    = i_Sig_MemWrite;
                  addr_d  = i_ALU_Result;
                  wdata_d = i_B;
                  lreg_d  = i_Write_Reg;
                  lrw_d   = i_Sig_RegWrite;
                  m2r_d   = i_Sig_MemtoReg;
`ifdef MEM_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end else begin
                  wbv_d    = 1'b1;
                  wbdata_d = i_ALU_Result;
                  wbreg_d  = i_Write_Reg;
                  wbrw_d   = i_Sig_RegWrite && (i_Write_Reg != '0);
               end
            end
         end
         ACCESS: begin
`ifdef MEM_TIMEOUT_EN
            cnt_d = cnt_q + CNT_W'(1);
`endif
            if (i_Mem_Ack) begin
               state_d  = IDLE;
               req_d    = 1'b0;
               wbv_d    = 1'b1;
               wbreg_d  = lreg_q;
               wbdata_d = (!we_q && m2r_q) ? i_Mem_Rdata : addr_q;
               wbrw_d   = lrw_q && !we_q && (lreg_q != '0);
            end
`ifdef MEM_TIMEOUT_EN
            else if (tmo) begin
               // Abandoned access retires as a no-op flagged by o_Mem_Error
               state_d  = IDLE;
               req_d    = 1'b0;
               wbv_d    = 1'b1;
               wbreg_d  = lreg_q;
               wbdata_d = '0;
               wbrw_d   = 1'b0;
               err_d    = 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q  <= IDLE;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         lreg_q   <= '0;
         lrw_q    <= 1'b0;
         m2r_q    <= 1'b0;
         wbv_q    <= 1'b0;
         wbrw_q   <= 1'b0;
         wbreg_q  <= '0;
         wbdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
         cnt_q    <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         lreg_q   <= lreg_d;
         lrw_q    <= lrw_d;
         m2r_q    <= m2r_d;
         wbv_q    <= wbv_d;
         wbrw_q   <= wbrw_d;
         wbreg_q  <= wbreg_d;
         wbdata_q <= wbdata_d;
`ifdef MEM_TIMEOUT_EN
         cnt_q    <= cnt_d;
         err_q    <= err_d;
`endif
      end
   end

   assign o_Stall       = (state_q == ACCESS);
   assign o_Mem_Req     = req_q;
   assign o_Mem_We      = we_q;
   assign o_Mem_Addr    = addr_q;
   assign o_Mem_Wdata   = wdata_q;
   assign o_WB_Valid    = wbv_q;
   assign o_WB_RegWrite = wbrw_q;
   assign o_WB_Reg      = wbreg_q;
   assign o_WB_Data     = wbdata_q;
`ifdef MEM_TIMEOUT_EN
   assign o_Mem_Error   = err_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
// Timeout scenario runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [15:0] alu, b;
   logic [2:0]  wreg;
   logic        mrd, mwr, rw, m2r;
   logic        stall, req, we;
   logic [15:0] addr, wdata;
   logic        ack;
   logic [15:0] rdata;
   logic        wbv, wbrw;
   logic [2:0]  wbreg;
   logic [15:0] wbdata;
`ifdef MEM_TIMEOUT_EN
   logic        err;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_access_stage #(
      .DATA_W(16),
      .REG_ADDR_W(3)
`ifdef MEM_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(4)
`endif
   ) dut (
      .i_Clk(clk),
      .i_Reset(rst),
      .i_Valid(valid),
      .i_ALU_Result(alu),
      .i_B(b),
      .i_Write_Reg(wreg),
      .i_Sig_MemRead(mrd),
      .i_Sig_MemWrite(mwr),
      .i_Sig_RegWrite(rw),
      .i_Sig_MemtoReg(m2r),
      .o_Stall(stall),
      .o_Mem_Req(req),
      .o_Mem_We(we),
      .o_Mem_Addr(addr),
      .o_Mem_Wdata(wdata),
      .i_Mem_Ack(ack),
      .i_Mem_Rdata(rdata),
`ifdef MEM_TIMEOUT_EN
      .o_Mem_Error(err),
`endif
      .o_WB_Valid(wbv),
      .o_WB_RegWrite(wbrw),
      .o_WB_Reg(wbreg),
      .o_WB_Data(wbdata)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      valid = 0; alu = 0; b = 0; wreg = 0;
      mrd = 0; mwr = 0; rw = 0; m2r = 0;
   endtask

   initial begin
      rst = 1; ack = 0; rdata = 0;
      idle_in();
      tick(); tick();
      chk("rst_req",    req,    0);
      chk("rst_stall",  stall,  0);
      chk("rst_wbv",    wbv,    0);
      chk("rst_wbdata", wbdata, 0);
      chk("rst_wbrw",   wbrw,   0);
      chk("rst_addr",   addr,   0);
      rst = 0;
      tick();

      // ALU op
      valid = 1; alu = 16'h1234; wreg = 3; rw = 1;
      chk("alu_nostall0", stall, 0);
      tick();
      idle_in();
      chk("alu_wbv",   wbv,    1);
      chk("alu_data",  wbdata, 16'h1234);
      chk("alu_reg",   wbreg,  3);
      chk("alu_rw",    wbrw,   1);
      chk("alu_stall", stall,  0);
      tick();
      chk("alu_pulse", wbv, 0);

      // Load, zero wait
      valid = 1; mrd = 1; m2r = 1; rw = 1; alu = 16'h0040; wreg = 5;
      tick();
      idle_in();
      chk("ld_req",   req,   1);
      chk("ld_we",    we,    0);
      chk("ld_addr",  addr,  16'h0040);
      chk("ld_stall", stall, 1);
      chk("ld_wbv0",  wbv,   0);
      ack = 1; rdata = 16'hBEEF;
      tick();
      ack = 0; rdata = 0;
      chk("ld_req_drop", req,    0);
      chk("ld_wbv",      wbv,    1);
      chk("ld_data",     wbdata, 16'hBEEF);
      chk("ld_reg",      wbreg,  5);
      chk("ld_rw",       wbrw,   1);
      chk("ld_stall0",   stall,  0);
      tick();
      chk("ld_pulse", wbv, 0);

      // Store, 3-cycle wait, then a held ALU op
      valid = 1; mwr = 1; alu = 16'h0010; b = 16'hA5A5; wreg = 2;
      tick();
      idle_in();
      valid = 1; alu = 16'h0777; wreg = 4; rw = 1;
      for (int k = 0; k < 3; k++) begin
         chk("st_req",   req,   1);
         chk("st_we",    we,    1);
         chk("st_addr",  addr,  16'h0010);
         chk("st_wdata", wdata, 16'hA5A5);
         chk("st_stall", stall, 1);
         chk("st_wbv0",  wbv,   0);
         if (k == 2) ack = 1;
         tick();
      end
      ack = 0;
      chk("st_wbv",    wbv,    1);
      chk("st_rw",     wbrw,   0);
      chk("st_data",   wbdata, 16'h0010);
      chk("st_stall0", stall,  0);
      chk("st_req0",   req,    0);
      tick();
      idle_in();
      chk("held_wbv",  wbv,    1);
      chk("held_data", wbdata, 16'h0777);
      chk("held_reg",  wbreg,  4);
      chk("held_rw",   wbrw,   1);
      tick();
      chk("held_once", wbv, 0);

      // Register $0 and spurious ack
      valid = 1; alu = 16'h0055; wreg = 0; rw = 1;
      tick();
      idle_in();
      chk("r0_wbv", wbv,   1);
      chk("r0_rw",  wbrw,  0);
      chk("r0_reg", wbreg, 0);
      ack = 1; rdata = 16'hDEAD;
      tick();
      ack = 0; rdata = 0;
      chk("spur_req",   req,   0);
      chk("spur_wbv",   wbv,   0);
      chk("spur_stall", stall, 0);

      // Reset mid-access
      valid = 1; mrd = 1; m2r = 1; rw = 1; alu = 16'h0080; wreg = 6;
      tick();
      idle_in();
      tick();
      chk("mid_req", req, 1);
      rst = 1;
      tick();
      rst = 0;
      chk("mid_req0",   req,    0);
      chk("mid_stall",  stall,  0);
      chk("mid_wbv",    wbv,    0);
      chk("mid_addr",   addr,   0);
      chk("mid_wbdata", wbdata, 0);
      ack = 1; rdata = 16'h1111;
      tick();
      ack = 0;
      chk("late_wbv", wbv, 0);
      chk("late_req", req, 0);

`ifdef MEM_TIMEOUT_EN
      valid = 1; mrd = 1; m2r = 1; rw = 1; alu = 16'h0100; wreg = 7;
      tick();
      idle_in();
      for (int k = 0; k < 4; k++) begin
         chk("to_req", req, 1);
         chk("to_err", err, 0);
         tick();
      end
      chk("to_req0", req,    0);
      chk("to_wbv",  wbv,    1);
      chk("to_data", wbdata, 0);
      chk("to_rw",   wbrw,   0);
      chk("to_err1", err,    1);
      chk("to_stall", stall, 0);
      tick();
      chk("to_errp", err, 0);
      chk("to_wbvp", wbv, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
